// File: rtl/dmi_initiator_if.sv
// Host command/response channel and DMI request channel of the debug initiator.
// master = initiator side, slave = host plus DMI responder side.
interface dmi_initiator_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_op;
  logic [6:0]  cmd_addr;
  logic [31:0] cmd_data;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_data;
  logic [1:0]  rsp_status;
  logic        dmi_valid;
  logic        dmi_ready;
  logic        dmi_write;
  logic [6:0]  dmi_addr;
  logic [31:0] dmi_wdata;
  logic [31:0] dmi_rdata;

  modport master (
    input  cmd_valid, cmd_op, cmd_addr, cmd_data, rsp_ready, dmi_ready, dmi_rdata,
    output cmd_ready, rsp_valid, rsp_data, rsp_status,
    output dmi_valid, dmi_write, dmi_addr, dmi_wdata
  );

  modport slave (
    output cmd_valid, cmd_op, cmd_addr, cmd_data, rsp_ready, dmi_ready, dmi_rdata,
    input  cmd_ready, rsp_valid, rsp_data, rsp_status,
    input  dmi_valid, dmi_write, dmi_addr, dmi_wdata
  );
endinterface

// File: rtl/dmi_initiator.sv
// DMI initiator: runs one host command (NOP/READ/WRITE/write-then-poll-busy) on the DMI
// and returns one response; all outputs registered, one command outstanding.
module dmi_initiator #(
  parameter int         TIMEOUT_CYCLES  = 64,
  parameter int         MAX_POLLS       = 255,
  parameter logic [6:0] ABSTRACTCS_ADDR = 7'h16,
  parameter int         BUSY_BIT        = 12
) (
  input  logic          clk,
  input  logic          reset,
  dmi_initiator_if.master bus
);

  localparam int WAIT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int POLL_W = $clog2(MAX_POLLS + 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [POLL_W-1:0] POLL_LAST = POLL_W'(MAX_POLLS);

  localparam logic [1:0] OP_NOP    = 2'd0;
  localparam logic [1:0] OP_READ   = 2'd1;
  localparam logic [1:0] OP_WRPOLL = 2'd3;

  localparam logic [1:0] ST_OK      = 2'd0;
  localparam logic [1:0] ST_BUSY    = 2'd2;
  localparam logic [1:0] ST_TIMEOUT = 2'd3;

  typedef enum logic [2:0] {S_IDLE, S_ACCESS, S_GAP, S_POLL, S_RESP} state_t;

  state_t              r_state,      w_state;
  logic                r_cmd_ready,  w_cmd_ready;
  logic                r_rsp_valid,  w_rsp_valid;
  logic [31:0]         r_rsp_data,   w_rsp_data;
  logic [1:0]          r_rsp_status, w_rsp_status;
  logic                r_dmi_valid,  w_dmi_valid;
  logic                r_dmi_write,  w_dmi_write;
  logic [6:0]          r_dmi_addr,   w_dmi_addr;
  logic [31:0]         r_dmi_wdata,  w_dmi_wdata;
  logic [1:0]          r_op,         w_op;
  logic                r_polling,    w_polling;
  logic [WAIT_W-1:0]   r_wait_cnt,   w_wait_cnt;
  logic [POLL_W-1:0]   r_poll_cnt,   w_poll_cnt;
  logic                w_match;

  assign w_match = r_dmi_valid && bus.dmi_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_cmd_ready  <= 1'b1;
      r_rsp_valid  <= 1'b0;
      r_rsp_data   <= '0;
      r_rsp_status <= '0;
      r_dmi_valid  <= 1'b0;
      r_dmi_write  <= 1'b0;
      r_dmi_addr   <= '0;
      r_dmi_wdata  <= '0;
      r_op         <= OP_NOP;
      r_polling    <= 1'b0;
      r_wait_cnt   <= '0;
      r_poll_cnt   <= '0;
    end else begin
      r_state      <= w_state;
      r_cmd_ready  <= w_cmd_ready;
      r_rsp_valid  <= w_rsp_valid;
      r_rsp_data   <= w_rsp_data;
      r_rsp_status <= w_rsp_status;
      r_dmi_valid  <= w_dmi_valid;
      r_dmi_write  <= w_dmi_write;
      r_dmi_addr   <= w_dmi_addr;
      r_dmi_wdata  <= w_dmi_wdata;
      r_op         <= w_op;
      r_polling    <= w_polling;
      r_wait_cnt   <= w_wait_cnt;
      r_poll_cnt   <= w_poll_cnt;
    end
  end

  always_comb begin
    w_state      = r_state;
    w_cmd_ready  = r_cmd_ready;
    w_rsp_valid  = r_rsp_valid;
    w_rsp_data   = r_rsp_data;
    w_rsp_status = r_rsp_status;
    w_dmi_valid  = r_dmi_valid;
    w_dmi_write  = r_dmi_write;
    w_dmi_addr   = r_dmi_addr;
    w_dmi_wdata  = r_dmi_wdata;
    w_op         = r_op;
    w_polling    = r_polling;
    w_wait_cnt   = r_wait_cnt;
    w_poll_cnt   = r_poll_cnt;

    case (r_state)
      S_IDLE: begin
        if (bus.cmd_valid && r_cmd_ready) begin
          w_cmd_ready = 1'b0;
          w_poll_cnt  = '0;
          w_polling   = 1'b0;
          w_op        = bus.cmd_op;
          if (bus.cmd_op == OP_NOP) begin
            w_rsp_valid  = 1'b1;
            w_rsp_data   = '0;
            w_rsp_status = ST_OK;
            w_state      = S_RESP;
          end else begin
            w_dmi_valid = 1'b1;
            w_dmi_write = (bus.cmd_op != OP_READ);
            w_dmi_addr  = bus.cmd_addr;
            w_dmi_wdata = bus.cmd_data;
            w_wait_cnt  = '0;
            w_state     = S_ACCESS;
          end
        end
      end

      S_ACCESS: begin
        if (w_match) begin
          // Drop valid right after the match so the responder never sees a second access.
          w_dmi_valid = 1'b0;
          if (r_polling) begin
            if (!bus.dmi_rdata[BUSY_BIT]) begin
              w_rsp_valid  = 1'b1;
              w_rsp_data   = bus.dmi_rdata;
              w_rsp_status = ST_OK;
              w_state      = S_RESP;
            end else begin
              w_poll_cnt = r_poll_cnt + 1'b1;
              if (w_poll_cnt == POLL_LAST) begin
                w_rsp_valid  = 1'b1;
                w_rsp_data   = bus.dmi_rdata;
                w_rsp_status = ST_BUSY;
                w_state      = S_RESP;
              end else begin
                w_state = S_GAP;
              end
            end
          end else if (r_op == OP_WRPOLL) begin
            w_polling = 1'b1;
            w_state   = S_GAP;
          end else begin
            w_rsp_valid  = 1'b1;
            w_rsp_data   = (r_op == OP_READ) ? bus.dmi_rdata : 32'd0;
            w_rsp_status = ST_OK;
            w_state      = S_RESP;
          end
        end else if (r_wait_cnt == WAIT_LAST) begin
          w_dmi_valid  = 1'b0;
          w_rsp_valid  = 1'b1;
          w_rsp_data   = '0;
          w_rsp_status = ST_TIMEOUT;
          w_state      = S_RESP;
        end else begin
          w_wait_cnt = r_wait_cnt + 1'b1;
        end
      end

      S_GAP: begin
        w_dmi_write = 1'b0;
        w_dmi_addr  = ABSTRACTCS_ADDR;
        w_dmi_wdata = '0;
        w_state     = S_POLL;
      end

      S_POLL: begin
        w_wait_cnt  = '0;
        w_dmi_valid = 1'b1;
        w_state     = S_ACCESS;
      end

      S_RESP: begin
        if (bus.rsp_ready) begin
          w_rsp_valid  = 1'b0;
          w_rsp_data   = '0;
          w_rsp_status = '0;
          w_cmd_ready  = 1'b1;
          w_state      = S_IDLE;
        end
      end

      default: w_state = S_IDLE;
    endcase
  end

  assign bus.cmd_ready  = r_cmd_ready;
  assign bus.rsp_valid  = r_rsp_valid;
  assign bus.rsp_data   = r_rsp_data;
  assign bus.rsp_status = r_rsp_status;
  assign bus.dmi_valid  = r_dmi_valid;
  assign bus.dmi_write  = r_dmi_write;
  assign bus.dmi_addr   = r_dmi_addr;
  assign bus.dmi_wdata  = r_dmi_wdata;

endmodule
